lr_pkt_arb: RTL and testbench

Packet-granularity arbiter that merges two 134-bit flit streams into the single stream feeding the local update path. Source 0 is the user-module pass-through traffic; source 1 is the local beacon/report generator. Each source gets a whole-packet grant via a ready handshake, and grants alternate round-robin. The block also enforces a grant timeout and counts dropped and illegal flits.

---
 rtl/lr_pkg.sv | 23 ++
 rtl/lr_sat_cnt.sv | 27 ++
 rtl/lr_pkt_arb.sv | 150 +++++++++++++++
 tb/tb_lr_pkt_arb.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lr_pkg.sv
// Shared definitions for the lreport-family packet blocks: flit layout and arbiter states.
// Combinational declarations only; no latency or flow control of its own.
// Flits carry a 2-bit header in the top bits that marks head, body and tail.
package lr_pkg;

    localparam int FLIT_W = 134;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_BODY = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    typedef struct packed {
        logic [1:0]        hdr;
        logic [FLIT_W-3:0] pay;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/lr_sat_cnt.sv
// Saturating event counter: adds 0..3 per cycle and clamps at all-ones.
// Latency: count visible one cycle after the increment is presented.
// Backpressure: none; always accepts its increment.
module lr_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   add,
    output logic [W-1:0] cnt
);

    logic [W:0] sum;

    assign sum = {1'b0, cnt} + {{(W-1){1'b0}}, add};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (sum[W]) begin
            cnt <= '1;
        end else begin
            cnt <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/lr_pkt_arb.sv
// Round-robin whole-packet arbiter merging two flit sources into one stream.
// Latency: 1 cycle input flit to out_*; ready is registered and trails the grant decision by 1 cycle.
// Backpressure: ready handshake per packet; non-granted or idle-state writes are dropped and counted.
module lr_pkt_arb
    import lr_pkg::*;
#(
    parameter int GRANT_TIMEOUT = 16,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_req,
    input  logic              s1_req,
    output logic              s0_ready,
    output logic              s1_ready,
    input  logic              s0_data_wr,
    input  logic [FLIT_W-1:0] s0_data,
    input  logic              s0_data_valid,
    input  logic              s0_data_valid_wr,
    input  logic              s1_data_wr,
    input  logic [FLIT_W-1:0] s1_data,
    input  logic              s1_data_valid,
    input  logic              s1_data_valid_wr,
    output logic              out_data_wr,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_data_valid,
    output logic              out_data_valid_wr,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  timeout_cnt
);

    localparam int TMR_W = $clog2(GRANT_TIMEOUT + 1);

    arb_state_e       state, nxt_state;
    logic             gnt, nxt_gnt;
    logic             rr_ptr, nxt_rr;
    logic [TMR_W-1:0] tmr, nxt_tmr;

    flit_t            g_flit;
    logic             g_wr, g_vld, g_vld_wr, o_wr;
    logic             fwd, err_inc, to_inc;
    logic [1:0]       drop_add;

    // gnt selects the owning source; the other one is only ever a drop candidate
    assign g_flit   = gnt ? s1_data          : s0_data;
    assign g_wr     = gnt ? s1_data_wr       : s0_data_wr;
    assign g_vld    = gnt ? s1_data_valid    : s0_data_valid;
    assign g_vld_wr = gnt ? s1_data_valid_wr : s0_data_valid_wr;
    assign o_wr     = gnt ? s0_data_wr       : s1_data_wr;

    always_comb begin
        nxt_state = state;
        nxt_gnt   = gnt;
        nxt_rr    = rr_ptr;
        nxt_tmr   = tmr;
        fwd       = 1'b0;
        err_inc   = 1'b0;
        to_inc    = 1'b0;
        drop_add  = 2'd0;
        case (state)
            ST_IDLE: begin
                drop_add = {1'b0, s0_data_wr} + {1'b0, s1_data_wr};
                if (s0_req || s1_req) begin
                    nxt_gnt   = (s0_req && s1_req) ? rr_ptr : s1_req;
                    nxt_state = ST_GRANT;
                    nxt_tmr   = '0;
                end
            end
            ST_GRANT: begin
                drop_add = {1'b0, o_wr};
                if (g_wr && g_flit.hdr == HDR_HEAD) begin
                    fwd       = 1'b1;
                    nxt_state = ST_XFER;
                end else begin
                    err_inc = g_wr;
                    // error flits still consume grant time so a broken source cannot hold the grant
                    if (tmr == TMR_W'(GRANT_TIMEOUT - 1)) begin
                        to_inc    = 1'b1;
                        nxt_rr    = ~gnt;
                        nxt_state = ST_IDLE;
                    end else begin
                        nxt_tmr = tmr + 1'b1;
                    end
                end
            end
            ST_XFER: begin
                drop_add = {1'b0, o_wr};
                if (g_wr) begin
                    fwd = 1'b1;
                    if (g_flit.hdr == HDR_TAIL) begin
                        nxt_rr    = ~gnt;
                        nxt_state = ST_IDLE;
                    end else if (g_flit.hdr == HDR_HEAD) begin
                        err_inc = 1'b1;
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            gnt               <= 1'b0;
            rr_ptr            <= 1'b0;
            tmr               <= '0;
            s0_ready          <= 1'b0;
            s1_ready          <= 1'b0;
            out_data_wr       <= 1'b0;
            out_data          <= '0;
            out_data_valid    <= 1'b0;
            out_data_valid_wr <= 1'b0;
        end else begin
            state             <= nxt_state;
            gnt               <= nxt_gnt;
            rr_ptr            <= nxt_rr;
            tmr               <= nxt_tmr;
            s0_ready          <= (nxt_state == ST_GRANT) && !nxt_gnt;
            s1_ready          <= (nxt_state == ST_GRANT) && nxt_gnt;
            out_data_wr       <= fwd;
            out_data          <= fwd ? g_flit : '0;
            out_data_valid    <= fwd & g_vld;
            out_data_valid_wr <= fwd & g_vld_wr;
        end
    end

    lr_sat_cnt #(.W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .add (drop_add),
        .cnt (drop_cnt)
    );

    lr_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .add ({1'b0, err_inc}),
        .cnt (err_cnt)
    );

    lr_sat_cnt #(.W(CNT_W)) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .add ({1'b0, to_inc}),
        .cnt (timeout_cnt)
    );

endmodule

// File: tb/tb_lr_pkt_arb.sv
// Bench for lr_pkt_arb: cycle-vector table plus sequences for packets, contention, timeout, reset and saturation.
// Forwarded flits are predicted into a scoreboard queue when driven and checked on output with their arrival cycle.
module tb_lr_pkt_arb;
    import lr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               s0_req, s1_req, s0_ready, s1_ready;
    logic               s0_data_wr, s1_data_wr;
    logic [FLIT_W-1:0]  s0_data, s1_data;
    logic               s0_data_valid, s0_data_valid_wr, s1_data_valid, s1_data_valid_wr;
    logic               out_data_wr, out_data_valid, out_data_valid_wr;
    logic [FLIT_W-1:0]  out_data;
    logic [15:0]        drop_cnt, err_cnt, timeout_cnt;

    // second, narrow-counter instance used only for saturation
    logic               z0_wr, z1_wr;
    logic               z_s0_ready, z_s1_ready, z_out_wr, z_out_v, z_out_vw;
    logic [FLIT_W-1:0]  z_out_data;
    logic [3:0]         z_drop, z_err, z_to;

    lr_pkt_arb #(.GRANT_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .s0_req(s0_req), .s1_req(s1_req), .s0_ready(s0_ready), .s1_ready(s1_ready),
        .s0_data_wr(s0_data_wr), .s0_data(s0_data),
        .s0_data_valid(s0_data_valid), .s0_data_valid_wr(s0_data_valid_wr),
        .s1_data_wr(s1_data_wr), .s1_data(s1_data),
        .s1_data_valid(s1_data_valid), .s1_data_valid_wr(s1_data_valid_wr),
        .out_data_wr(out_data_wr), .out_data(out_data),
        .out_data_valid(out_data_valid), .out_data_valid_wr(out_data_valid_wr),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt), .timeout_cnt(timeout_cnt)
    );

    lr_pkt_arb #(.GRANT_TIMEOUT(16), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .s0_req(1'b0), .s1_req(1'b0), .s0_ready(z_s0_ready), .s1_ready(z_s1_ready),
        .s0_data_wr(z0_wr), .s0_data({FLIT_W{1'b0}}),
        .s0_data_valid(1'b0), .s0_data_valid_wr(1'b0),
        .s1_data_wr(z1_wr), .s1_data({FLIT_W{1'b0}}),
        .s1_data_valid(1'b0), .s1_data_valid_wr(1'b0),
        .out_data_wr(z_out_wr), .out_data(z_out_data),
        .out_data_valid(z_out_v), .out_data_valid_wr(z_out_vw),
        .drop_cnt(z_drop), .err_cnt(z_err), .timeout_cnt(z_to)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [FLIT_W-1:0] d;
        logic              v;
        logic              vw;
        int                c;
    } sb_t;
    sb_t sb_q[$];

    task automatic chk(input string nm, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] h, input int tag);
        logic [FLIT_W-1:0] f;
        f          = '0;
        f[133:132] = h;
        f[131:100] = 32'hA5C3_0000 ^ tag;
        f[31:0]    = tag;
        return f;
    endfunction

    // drive one source for the coming edge; predict the output when it should be forwarded
    task automatic put(input int s, input logic wr, input logic [1:0] h, input int tag, input logic fwd_exp);
        logic [FLIT_W-1:0] f;
        logic v, vw;
        f  = wr ? mk(h, tag) : '0;
        v  = wr && (h == HDR_TAIL);
        vw = wr && (h != HDR_BODY);
        if (s == 0) begin
            s0_data_wr = wr; s0_data = f; s0_data_valid = v; s0_data_valid_wr = vw;
        end else begin
            s1_data_wr = wr; s1_data = f; s1_data_valid = v; s1_data_valid_wr = vw;
        end
        if (wr && fwd_exp) sb_q.push_back('{d: f, v: v, vw: vw, c: cyc + 1});
    endtask

    task automatic idle_inputs();
        put(0, 1'b0, 2'b00, 0, 1'b0);
        put(1, 1'b0, 2'b00, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_data_wr) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_flit", out_data, '0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_valid", out_data_valid, e.v);
                    chk("out_valid_wr", out_data_valid_wr, e.vw);
                    chk("out_latency_cycle", cyc, e.c);
                end
            end else if (out_data != '0 || out_data_valid || out_data_valid_wr) begin
                chk("out_idle_zero", {out_data_valid, out_data_valid_wr, out_data[131:0]}, '0);
            end
        end
    end

    typedef struct {
        logic       r0, r1;
        logic       w0; logic [1:0] h0;
        logic       w1; logic [1:0] h1;
        logic       fsrc, efwd;
        logic       rdy0, rdy1;
        int         drop, err;
    } vec_t;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s0_req = 1'b0; s1_req = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic serve_pkt(output int src, output int head_c, output int tail_c);
        bit got;
        got = 1'b0;
        src = 0; head_c = 0; tail_c = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            if (s0_ready || s1_ready) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            chk("serve_grant_timeout", 0, 1);
        end else begin
            src = s1_ready ? 1 : 0;
            head_c = cyc;
            put(src, 1'b1, HDR_HEAD, 500 + cyc, 1'b1); @(negedge clk);
            put(src, 1'b1, HDR_BODY, 500 + cyc, 1'b1); @(negedge clk);
            tail_c = cyc;
            put(src, 1'b1, HDR_TAIL, 500 + cyc, 1'b1); @(negedge clk);
            put(src, 1'b0, 2'b00, 0, 1'b0);
        end
    endtask

    vec_t vt[14];
    int   src_a, src_b, src_c, h_a, t_a, h_b, t_b, h_c, t_c, rcnt;
    bit   fell;

    initial begin
        vt[0]  = '{1,0, 0,2'b00, 0,2'b00, 0,0, 1,0, 0,0};
        vt[1]  = '{0,0, 1,2'b11, 0,2'b00, 0,0, 1,0, 0,1};
        vt[2]  = '{0,0, 1,2'b01, 0,2'b00, 0,1, 0,0, 0,1};
        vt[3]  = '{0,0, 1,2'b11, 1,2'b11, 0,1, 0,0, 1,1};
        vt[4]  = '{0,0, 0,2'b00, 0,2'b00, 0,0, 0,0, 1,1};
        vt[5]  = '{0,0, 1,2'b01, 0,2'b00, 0,1, 0,0, 1,2};
        vt[6]  = '{0,0, 0,2'b00, 1,2'b01, 0,0, 0,0, 2,2};
        vt[7]  = '{0,0, 1,2'b10, 1,2'b11, 0,1, 0,0, 3,2};
        vt[8]  = '{0,0, 1,2'b11, 0,2'b00, 0,0, 0,0, 4,2};
        vt[9]  = '{1,1, 1,2'b11, 1,2'b11, 0,0, 0,1, 6,2};
        vt[10] = '{1,0, 0,2'b00, 1,2'b01, 1,1, 0,0, 6,2};
        vt[11] = '{1,0, 0,2'b00, 1,2'b10, 1,1, 0,0, 6,2};
        vt[12] = '{1,0, 0,2'b00, 0,2'b00, 0,0, 1,0, 6,2};
        vt[13] = '{1,0, 0,2'b00, 0,2'b00, 0,0, 1,0, 6,2};

        s0_req = 1'b0; s1_req = 1'b0; z0_wr = 1'b0; z1_wr = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst_out_wr", out_data_wr, 0);
        chk("rst_out_data", out_data, '0);
        chk("rst_ready", {s0_ready, s1_ready}, 0);
        chk("rst_counters", {drop_cnt, err_cnt, timeout_cnt}, 0);
        rst = 1'b0;

        // cycle vectors: grant, error in GRANT, interference, mid-packet head, idle drops, rr turn
        for (int i = 0; i < 14; i++) begin
            s0_req = vt[i].r0; s1_req = vt[i].r1;
            put(0, vt[i].w0, vt[i].h0, 2 * i,     vt[i].efwd && vt[i].fsrc == 1'b0);
            put(1, vt[i].w1, vt[i].h1, 2 * i + 1, vt[i].efwd && vt[i].fsrc == 1'b1);
            @(negedge clk);
            chk($sformatf("vec%0d_s0_ready", i), s0_ready, vt[i].rdy0);
            chk($sformatf("vec%0d_s1_ready", i), s1_ready, vt[i].rdy1);
            chk($sformatf("vec%0d_drop_cnt", i), drop_cnt, vt[i].drop);
            chk($sformatf("vec%0d_err_cnt", i), err_cnt, vt[i].err);
            chk($sformatf("vec%0d_timeout_cnt", i), timeout_cnt, 0);
        end

        // reset mid-XFER: outputs clear immediately, no tail emitted
        s0_req = 1'b0;
        put(0, 1'b1, HDR_HEAD, 90, 1'b1); @(negedge clk);
        put(0, 1'b1, HDR_BODY, 91, 1'b1); @(negedge clk);
        put(0, 1'b0, 2'b00, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_wr", out_data_wr, 0);
        chk("arst_out_data", out_data, '0);
        chk("arst_out_valid", {out_data_valid, out_data_valid_wr}, 0);
        chk("arst_counters", {drop_cnt, err_cnt, timeout_cnt}, 0);
        chk("arst_state", 134'(dut.state), 134'(ST_IDLE));
        chk("arst_sb_empty", sb_q.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single-source 13-flit packet on s1
        s1_req = 1'b1;
        @(negedge clk);
        chk("pkt13_s1_ready", s1_ready, 1);
        s1_req = 1'b0;
        for (int i = 0; i < 13; i++) begin
            put(1, 1'b1, (i == 0) ? HDR_HEAD : (i == 12) ? HDR_TAIL : HDR_BODY, 200 + i, 1'b1);
            @(negedge clk);
            if (i == 0) chk("pkt13_ready_fell", s1_ready, 0);
        end
        put(1, 1'b0, 2'b00, 0, 1'b0);
        @(negedge clk);
        chk("pkt13_counters", {drop_cnt, err_cnt, timeout_cnt}, 0);
        chk("pkt13_sb_empty", sb_q.size(), 0);

        // contention: s0, s1, s0 with a 2-cycle tail-to-head spacing
        do_reset();
        s0_req = 1'b1; s1_req = 1'b1;
        serve_pkt(src_a, h_a, t_a);
        serve_pkt(src_b, h_b, t_b);
        serve_pkt(src_c, h_c, t_c);
        s0_req = 1'b0; s1_req = 1'b0;
        chk("rr_first_src", src_a, 0);
        chk("rr_second_src", src_b, 1);
        chk("rr_third_src", src_c, 0);
        chk("rr_gap_ab", h_b - t_a, 2);
        chk("rr_gap_bc", h_c - t_b, 2);
        repeat (3) @(negedge clk);
        chk("rr_sb_empty", sb_q.size(), 0);

        // grant timeout on s0, then s1 is served
        do_reset();
        s0_req = 1'b1; s1_req = 1'b1;
        rcnt = 0; fell = 1'b0;
        for (int k = 0; k < 40 && !fell; k++) begin
            @(negedge clk);
            if (s0_ready) rcnt++;
            else if (rcnt > 0) fell = 1'b1;
        end
        chk("to_ready_fell", fell, 1);
        chk("to_ready_cycles", rcnt, 16);
        chk("to_timeout_cnt", timeout_cnt, 1);
        chk("to_s1_not_yet", s1_ready, 0);
        @(negedge clk);
        chk("to_s1_granted", s1_ready, 1);
        chk("to_s0_not_granted", s0_ready, 0);
        s0_req = 1'b0; s1_req = 1'b0;

        // counter saturation on the 4-bit instance
        do_reset();
        z0_wr = 1'b1;
        repeat (14) @(negedge clk);
        chk("sat_drop_14", z_drop, 14);
        z1_wr = 1'b1;
        @(negedge clk);
        chk("sat_double_clamp", z_drop, 15);
        z1_wr = 1'b0;
        @(negedge clk);
        chk("sat_hold", z_drop, 15);
        z0_wr = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
